// File: rtl/snoopy_pkg.sv
// Shared definitions for the Snoopy game blocks: motion state encodings and
// the default coordinate/velocity widths used by the horizontal FSM, the
// renderer and the vertical physics engine.
package snoopy_pkg;

  localparam int Y_W_DEF = 7;
  localparam int V_W_DEF = 5;

  typedef enum logic [1:0] {
    S_GROUND = 2'd0,
    S_RISE   = 2'd1,
    S_FALL   = 2'd2
  } state_t;

endpackage

// File: rtl/snoopy_vertical_physics_if.sv
// Bus between the frame/input logic and the vertical physics engine.
// tick and jump are levels sampled on every clock edge (tick is a one-cycle
// frame-step strobe, jump is the debounced button level); there is no
// valid/ready handshake: every tick is consumed on the cycle it is high and
// the status outputs are registered and valid every cycle.
interface snoopy_vertical_physics_if
  import snoopy_pkg::*;
#(
  parameter int Y_W  = Y_W_DEF,
  parameter int JC_W = 2
);
  logic            tick;
  logic            jump;
  logic [Y_W-1:0]  snoopy_y;
  logic            on_ground;
  logic [JC_W-1:0] jump_count;
  state_t          state;

  modport master (
    output tick, jump,
    input  snoopy_y, on_ground, jump_count, state
  );

  modport slave (
    input  tick, jump,
    output snoopy_y, on_ground, jump_count, state
  );
endinterface

// File: rtl/snoopy_edge_detect.sv
// Rising/falling edge detector for a button level. Reused for every button.
module snoopy_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise,
  output logic fall
);
  logic in_q;

  // Remember the previous level of the input
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) in_q <= 1'b0;
    else        in_q <= in;
  end

  assign rise = in & ~in_q;
  assign fall = ~in & in_q;
endmodule

// File: rtl/snoopy_vertical_physics.sv
// Vertical-motion engine for Snoopy: gravity-driven jump/fall with a signed
// velocity, multiple air jumps, ceiling and ground clamps. One physics step
// per frame tick; y grows downward so a jump drives the velocity negative.
// Optional feature macro: SNOOPY_VAR_JUMP_EN (variable jump height -- a
// release while rising halves the upward speed on the next tick).
module snoopy_vertical_physics
  import snoopy_pkg::*;
#(
  parameter int Y_W        = Y_W_DEF,
  parameter int V_W        = V_W_DEF,
  parameter int GROUND_Y   = 100,
  parameter int CEIL_Y     = 0,
  parameter int JUMP_V     = 6,
  parameter int GRAVITY    = 1,
  parameter int MAX_FALL_V = 7,
  parameter int MAX_JUMPS  = 2
) (
  input logic                  clock,
  input logic                  reset,
  snoopy_vertical_physics_if.slave bus
);
  localparam int JC_W = $clog2(MAX_JUMPS + 1);
  // Two guard bits so y+vy never wraps before the clamps look at it
  localparam int S_W  = Y_W + 2;

  localparam logic signed [S_W-1:0] CEIL_S   = S_W'(CEIL_Y);
  localparam logic signed [S_W-1:0] GROUND_S = S_W'(GROUND_Y);
  localparam logic signed [S_W-1:0] JUMP_S   = S_W'(JUMP_V);
  localparam logic signed [S_W-1:0] GRAV_S   = S_W'(GRAVITY);
  localparam logic signed [S_W-1:0] MAXF_S   = S_W'(MAX_FALL_V);
  localparam logic signed [S_W-1:0] ONE_S    = S_W'(1);
  localparam logic [JC_W-1:0]       MAX_JC   = JC_W'(MAX_JUMPS);

  logic jump_rise;
  logic jump_fall;

  snoopy_edge_detect u_jump_edge (
    .clock (clock),
    .reset (reset),
    .in    (bus.jump),
    .rise  (jump_rise),
    .fall  (jump_fall)
  );

  logic [Y_W-1:0]        y_q;
  logic signed [V_W-1:0] vy_q;
  state_t                state_q;
  logic [JC_W-1:0]       jc_q;
  logic                  on_ground_q;
  logic                  pending_q;

  logic [Y_W-1:0]        y_n;
  logic [V_W-1:0]        vy_n;
  state_t                st_n;
  logic [JC_W-1:0]       jc_n;
  logic                  req;
  logic                  accept;
  logic signed [S_W-1:0] vy_w;
  logic signed [S_W-1:0] ny_w;

`ifdef SNOOPY_VAR_JUMP_EN
  logic cut_q;
  logic cut_eff;
  // A release on the tick cycle itself counts, like a press does
  assign cut_eff = (cut_q | jump_fall) & (state_q == S_RISE);
`else
  logic unused_jump_fall;
  assign unused_jump_fall = jump_fall;
`endif

  // Next physics step: impulse, optional cut, move, clamp, gravity
  always_comb begin
    req    = pending_q | jump_rise;
    accept = req & ((state_q == S_GROUND) | (jc_q < MAX_JC));
    vy_w   = {{(S_W-V_W){vy_q[V_W-1]}}, vy_q};
    st_n   = state_q;
    jc_n   = jc_q;
    y_n    = y_q;

    if (accept) begin
      vy_w = -JUMP_S;
      jc_n = jc_q + 1'b1;
      st_n = S_RISE;
    end
`ifdef SNOOPY_VAR_JUMP_EN
    // Halve toward zero: bias negative values by one before the shift
    else if (cut_eff) begin
      if (vy_w[S_W-1]) vy_w = vy_w + ONE_S;
      vy_w = vy_w >>> 1;
    end
`endif

    ny_w = $signed({2'b00, y_q}) + vy_w;

    if (ny_w <= CEIL_S) begin
      y_n  = Y_W'(CEIL_Y);
      vy_w = '0;
      st_n = S_FALL;
    end else if ((ny_w >= GROUND_S) && (vy_w >= 0)) begin
      y_n  = Y_W'(GROUND_Y);
      vy_w = '0;
      st_n = S_GROUND;
      jc_n = '0;
    end else begin
      y_n  = ny_w[Y_W-1:0];
    end

    if (st_n != S_GROUND) begin
      vy_w = vy_w + GRAV_S;
      if (vy_w > MAXF_S) vy_w = MAXF_S;
      if ((st_n == S_RISE) && (vy_w >= 0)) st_n = S_FALL;
    end

    vy_n = vy_w[V_W-1:0];
  end

  // Motion FSM and kinematic registers; everything but the press/release
  // latches holds between ticks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y_q         <= Y_W'(GROUND_Y);
      vy_q        <= '0;
      state_q     <= S_GROUND;
      jc_q        <= '0;
      on_ground_q <= 1'b1;
      pending_q   <= 1'b0;
`ifdef SNOOPY_VAR_JUMP_EN
      cut_q       <= 1'b0;
`endif
    end else if (bus.tick) begin
      y_q         <= y_n;
      vy_q        <= vy_n;
      state_q     <= st_n;
      jc_q        <= jc_n;
      on_ground_q <= (st_n == S_GROUND);
      pending_q   <= 1'b0;
`ifdef SNOOPY_VAR_JUMP_EN
      cut_q       <= 1'b0;
`endif
    end else begin
      if (jump_rise) pending_q <= 1'b1;
`ifdef SNOOPY_VAR_JUMP_EN
      if (jump_fall && (state_q == S_RISE)) cut_q <= 1'b1;
`endif
    end
  end

  assign bus.snoopy_y   = y_q;
  assign bus.on_ground  = on_ground_q;
  assign bus.jump_count = jc_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_snoopy_vertical_physics.sv
// Bench for snoopy_vertical_physics: directed trajectories from the
// behaviour description plus randomized tick/jump traffic checked against
// an integer reference model. A second instance with the ceiling at 90
// shares the inputs and is checked only in the ceiling scenario.
module tb_snoopy_vertical_physics;
  import snoopy_pkg::*;

  localparam int GROUND = 100;
  localparam int JUMPV  = 6;
  localparam int MAXF   = 7;
  localparam int MAXJ   = 2;

  logic clock;
  logic reset;
  logic tick;
  logic jump;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (main instance, ceiling at 0)
  int m_y, m_vy, m_st, m_jc;
  bit m_pend, m_jq, m_cut;

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  snoopy_vertical_physics_if #(.Y_W(7), .JC_W(2)) bus  ();
  snoopy_vertical_physics_if #(.Y_W(7), .JC_W(2)) cbus ();

  assign bus.tick  = tick;
  assign bus.jump  = jump;
  assign cbus.tick = tick;
  assign cbus.jump = jump;

  snoopy_vertical_physics dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  snoopy_vertical_physics #(.CEIL_Y(90)) dut_ceil (
    .clock (clock),
    .reset (reset),
    .bus   (cbus)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_y = GROUND; m_vy = 0; m_st = 0; m_jc = 0;
    m_pend = 0; m_jq = 0; m_cut = 0;
  endtask

  // One clock of the behavioural rules, in plain integer arithmetic
  task automatic model_clock(input bit tk, input bit jp);
    bit rise, fall, go;
    int vy, ny;
    rise = jp && !m_jq;
    fall = !jp && m_jq;
    if (tk) begin
      vy = m_vy;
      go = (m_pend || rise) && (m_st == 0 || m_jc < MAXJ);
      if (go) begin
        vy = -JUMPV;
        m_jc++;
        m_st = 1;
      end
`ifdef SNOOPY_VAR_JUMP_EN
      else if (m_st == 1 && (m_cut || fall)) vy = vy / 2;
`endif
      ny = m_y + vy;
      if (ny <= 0) begin
        m_y = 0; vy = 0; m_st = 2;
      end else if (ny >= GROUND && vy >= 0) begin
        m_y = GROUND; vy = 0; m_st = 0; m_jc = 0;
      end else begin
        m_y = ny;
      end
      if (m_st != 0) begin
        vy = (vy + 1 > MAXF) ? MAXF : vy + 1;
        if (m_st == 1 && vy >= 0) m_st = 2;
      end
      m_vy = vy;
      m_pend = 0;
      m_cut = 0;
    end else begin
      if (rise) m_pend = 1;
      if (fall && m_st == 1) m_cut = 1;
    end
    m_jq = jp;
  endtask

  // Driver: called at a falling edge; applies inputs for one clock, then
  // compares the main instance against the model just after the edge
  task automatic step(input bit tk, input bit jp);
    tick = tk;
    jump = jp;
    model_clock(tk, jp);
    @(posedge clock);
    #1;
    check("y",          int'(bus.snoopy_y),   m_y);
    check("state",      int'(bus.state),      m_st);
    check("jump_count", int'(bus.jump_count), m_jc);
    check("on_ground",  int'(bus.on_ground),  int'(m_st == 0));
    @(negedge clock);
    tick = 1'b0;
  endtask

  task automatic run_to_ground();
    for (int i = 0; i < 40 && m_st != 0; i++) step(1'b1, 1'b0);
    check("landed", int'(bus.on_ground), 1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    tick = 1'b0;
    jump = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  int single_y [13] = '{94, 89, 85, 82, 80, 79, 79, 80, 82, 85, 89, 94, 100};
  int ceil_y   [6]  = '{94, 90, 91, 93, 96, 100};

  initial begin
    int apex;
    int exp_apex;
    tick  = 1'b0;
    jump  = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_y",     int'(bus.snoopy_y),   GROUND);
    check("rst_state", int'(bus.state),      0);
    check("rst_jc",    int'(bus.jump_count), 0);
    check("rst_og",    int'(bus.on_ground),  1);
    @(negedge clock);

    // Single jump: press and release between ticks, then a tick per frame
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("no_tick_hold", int'(bus.snoopy_y), GROUND);
    for (int k = 0; k < 13; k++) begin
      step(1'b1, 1'b0);
      check("single_y", int'(bus.snoopy_y), single_y[k]);
      if (k < 6) check("ceil_y", int'(cbus.snoopy_y), ceil_y[k]);
      if (k == 1) check("ceil_state", int'(cbus.state), int'(S_FALL));
      if (k == 4) check("rise_t5", int'(bus.state), int'(S_RISE));
      if (k == 5) check("fall_t6", int'(bus.state), int'(S_FALL));
      step(1'b0, 1'b0);
    end
    check("single_og", int'(bus.on_ground), 1);

    // Double jump, then an ignored third press
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("double_y",  int'(bus.snoopy_y),   83);
    check("double_jc", int'(bus.jump_count), 2);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("triple_y",  int'(bus.snoopy_y),   78);
    check("triple_jc", int'(bus.jump_count), 2);
    run_to_ground();
    check("land_jc", int'(bus.jump_count), 0);

    // Press held across ticks gives a single impulse
    step(1'b1, 1'b1);
    check("coincident_y", int'(bus.snoopy_y), 94);
    step(1'b1, 1'b1);
    check("held_y",  int'(bus.snoopy_y),   89);
    check("held_jc", int'(bus.jump_count), 1);
    step(1'b0, 1'b0);
    run_to_ground();

    // Early release: variable height only when the feature is built in
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
`ifdef SNOOPY_VAR_JUMP_EN
    check("cut_y", int'(bus.snoopy_y), 92);
    exp_apex = 91;
`else
    check("cut_y", int'(bus.snoopy_y), 89);
    exp_apex = 79;
`endif
    apex = int'(bus.snoopy_y);
    for (int i = 0; i < 40 && m_st != 0; i++) begin
      step(1'b1, 1'b0);
      if (int'(bus.snoopy_y) < apex) apex = int'(bus.snoopy_y);
    end
    check("apex", apex, exp_apex);

    // Asynchronous reset mid-air at y=85, observed before any clock edge
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("pre_reset_y", int'(bus.snoopy_y), 85);
    #2;
    reset = 1'b0;
    #1;
    check("async_y",     int'(bus.snoopy_y),   GROUND);
    check("async_state", int'(bus.state),      0);
    check("async_jc",    int'(bus.jump_count), 0);
    do_reset();

    // Randomized tick/jump traffic
    for (int c = 0; c < 3000; c++) begin
      bit tk, jp;
      tk = ($urandom_range(0, 2) == 0);
      jp = ($urandom_range(0, 3) == 0) ? ~jump : jump;
      step(tk, jp);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
